// File: rtl/aes_pkg.sv
// Shared AES types and constants for the inverse-cipher datapath.
// Holds the inverse S-box table, state/byte types and the round-engine FSM encoding.
package aes_pkg;

    localparam int NUM_ROUNDS_128 = 10;
    localparam int NUM_ROUNDS_192 = 12;
    localparam int NUM_ROUNDS_256 = 14;

    typedef logic [127:0] state_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_inv_sub_shift.sv
// InvShiftRows followed by 16 InvSubBytes lookups on a column-major state (s0 = [127:120]).
// Purely combinational, zero latency, no flow control.
module aes_inv_sub_shift
    import aes_pkg::*;
(
    input  logic [127:0] i_dat,
    output logic [127:0] o_dat
);

    // Output byte (row r, column c) comes from input column (c - r) mod 4: row r rotates right by r.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST = 4 * c + r;
            localparam int SRC = 4 * ((c - r + 4) % 4) + r;
            byte_t w_src;
            assign w_src = i_dat[127 - 8 * SRC -: 8];
            assign o_dat[127 - 8 * DST -: 8] = INV_SBOX[w_src];
        end
    end

endmodule

// File: rtl/inv_mixcolumns.sv
// AES InvMixColumns over four column-major 32-bit columns.
// Purely combinational, zero latency, no flow control.
module inv_mixcolumns
    import aes_pkg::*;
(
    input  logic [127:0] i_dat,
    output logic [127:0] o_dat
);

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant: bit i of k adds b * 2^i.
    function automatic byte_t gmul(input byte_t b, input logic [3:0] k);
        byte_t p;
        byte_t acc;
        p   = b;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        byte_t w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = i_dat[127 - 32 * c -: 8];
        assign w_a1 = i_dat[119 - 32 * c -: 8];
        assign w_a2 = i_dat[111 - 32 * c -: 8];
        assign w_a3 = i_dat[103 - 32 * c -: 8];
        assign o_dat[127 - 32 * c -: 8] = gmul(w_a0, 4'he) ^ gmul(w_a1, 4'hb) ^ gmul(w_a2, 4'hd) ^ gmul(w_a3, 4'h9);
        assign o_dat[119 - 32 * c -: 8] = gmul(w_a0, 4'h9) ^ gmul(w_a1, 4'he) ^ gmul(w_a2, 4'hb) ^ gmul(w_a3, 4'hd);
        assign o_dat[111 - 32 * c -: 8] = gmul(w_a0, 4'hd) ^ gmul(w_a1, 4'h9) ^ gmul(w_a2, 4'he) ^ gmul(w_a3, 4'hb);
        assign o_dat[103 - 32 * c -: 8] = gmul(w_a0, 4'hb) ^ gmul(w_a1, 4'hd) ^ gmul(w_a2, 4'h9) ^ gmul(w_a3, 4'he);
    end

endmodule

// File: rtl/aes_inv_round_engine.sv
// Iterative AES decryption, one inverse round per cycle; optional abort port under AES_INV_ROUND_ABORT_EN.
// Latency: out_valid NUM_ROUNDS+1 edges after accept (accept edge counted); initiation interval NUM_ROUNDS+2.
// Backpressure: result held in DONE until out_ready; in_ready is low from accept until return to IDLE.
module aes_inv_round_engine
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_128,
    parameter int KIDX_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    output logic [KIDX_W-1:0] rk_idx,
    input  logic [127:0]      rk_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data
`ifdef AES_INV_ROUND_ABORT_EN
    ,
    input  logic              abort
`endif
);

    fsm_t              r_fsm;
    state_t            r_state;
    logic [KIDX_W-1:0] r_rnd;
    logic [KIDX_W-1:0] r_rk_idx;
    logic              r_in_ready;
    logic              r_out_valid;

    state_t w_sub;
    state_t w_t;
    state_t w_mix;
    logic   w_abort;

`ifdef AES_INV_ROUND_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    aes_inv_sub_shift u_sub_shift (
        .i_dat (r_state),
        .o_dat (w_sub)
    );

    assign w_t = w_sub ^ rk_data;

    inv_mixcolumns u_inv_mixcolumns (
        .i_dat (w_t),
        .o_dat (w_mix)
    );

    // rk_idx is registered with the next-state value so the key store sees it from the start of each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_state     <= '0;
            r_rnd       <= '0;
            r_rk_idx    <= KIDX_W'(NUM_ROUNDS);
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (w_abort) begin
            // An abort seen in IDLE just suppresses that cycle's accept; the state register is kept.
            if (r_fsm != IDLE) begin
                r_fsm       <= IDLE;
                r_rk_idx    <= KIDX_W'(NUM_ROUNDS);
                r_in_ready  <= 1'b1;
                r_out_valid <= 1'b0;
            end
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state    <= in_data ^ rk_data;
                        r_rnd      <= KIDX_W'(NUM_ROUNDS - 1);
                        r_rk_idx   <= KIDX_W'(NUM_ROUNDS - 1);
                        r_in_ready <= 1'b0;
                        r_fsm      <= ROUND;
                    end
                end
                ROUND: begin
                    if (r_rnd != '0) begin
                        r_state  <= w_mix;
                        r_rnd    <= r_rnd - 1'b1;
                        r_rk_idx <= r_rnd - 1'b1;
                    end else begin
                        r_state     <= w_t;
                        r_rk_idx    <= '0;
                        r_out_valid <= 1'b1;
                        r_fsm       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_rk_idx    <= KIDX_W'(NUM_ROUNDS);
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_fsm       <= IDLE;
                    end
                end
                default: begin
                    r_rk_idx    <= KIDX_W'(NUM_ROUNDS);
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_fsm       <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_state;
    assign rk_idx    = r_rk_idx;

endmodule

// File: tb/tb_aes_inv_round_engine.sv
// Bench for aes_inv_round_engine: FIPS-197 C.1 key store, plaintext scoreboard, handshake monitor.
// Covers reset values, KAT, backpressure, busy-ignore, back-to-back, mid-op reset and (if enabled) abort.
module tb_aes_inv_round_engine;

    localparam int NR = 10;
    localparam logic [127:0] KAT_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
`ifdef AES_INV_ROUND_ABORT_EN
    logic         abort;
`endif

    logic [127:0] rk_mem [0:15];
    logic [127:0] exp_q [$];
    int n_chk = 0;
    int n_fail = 0;
    int edge_cnt = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    int acc_edge = 0;
    int prev_acc_edge = 0;
    logic         prev_ov = 1'b0;
    logic         prev_or = 1'b0;
    logic [127:0] prev_od = '0;

    aes_inv_round_engine #(.NUM_ROUNDS(NR), .KIDX_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef AES_INV_ROUND_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    assign rk_data = rk_mem[rk_idx];

    task automatic chk_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Handshake monitor: sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
            prev_or = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                prev_acc_edge = acc_edge;
                acc_edge      = edge_cnt + 1;
                acc_cnt++;
            end
            if (out_valid && !prev_ov)
                chk_val("latency", 128'(edge_cnt - acc_edge + 1), 128'(NR + 1));
            if (out_valid && prev_ov && !prev_or) begin
                chk_val("hold_dat", out_data, prev_od);
                chk_val("hold_rdy", 128'(in_ready), 128'(0));
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) chk_val("unexp_out", 128'(out_valid), 128'(0));
                else chk_val("plaintext", out_data, exp_q.pop_front());
            end
            prev_ov = out_valid;
            prev_or = out_ready;
            prev_od = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_kat(input bit chk_rk);
        int n;
        exp_q.push_back(KAT_PT);
        in_data  = KAT_CT;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_val("accept_rdy", 128'(in_ready), 128'(1));
        if (chk_rk) chk_val("rk_idx_acc", 128'(rk_idx), 128'(NR));
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        if (chk_rk) begin
            for (int r = NR - 1; r >= 0; r--) begin
                @(negedge clk);
                chk_val("rk_idx_rnd", 128'(rk_idx), 128'(r));
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk_val("drain", 128'(exp_q.size()), 128'(0));
        tick();
    endtask

    initial begin
        int a0, o0, k, n;
        for (int i = 0; i < 16; i++) rk_mem[i] = '0;
        rk_mem[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk_mem[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rk_mem[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rk_mem[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rk_mem[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rk_mem[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rk_mem[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rk_mem[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rk_mem[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rk_mem[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rk_mem[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef AES_INV_ROUND_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_val("rst_in_ready", 128'(in_ready), 128'(1));
        chk_val("rst_out_valid", 128'(out_valid), 128'(0));
        chk_val("rst_out_data", out_data, 128'(0));
        chk_val("rst_rk_idx", 128'(rk_idx), 128'(NR));
        tick();
        rst = 1'b0;

        // Known-answer block with key-index sequence.
        send_kat(1'b1);
        wait_drain();

        // Backpressure: result must hold for 20 cycles with out_ready low.
        out_ready = 1'b0;
        send_kat(1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk_val("bp_valid", 128'(out_valid), 128'(1));
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        tick();
        chk_val("bp_ov_drop", 128'(out_valid), 128'(0));
        chk_val("bp_in_ready", 128'(in_ready), 128'(1));
        wait_drain();

        // Busy-ignore: all-ones block offered mid-operation must not be taken.
        a0 = acc_cnt;
        o0 = out_cnt;
        send_kat(1'b0);
        repeat (2) tick();
        in_valid = 1'b1;
        in_data  = '1;
        repeat (3) tick();
        in_valid = 1'b0;
        in_data  = '0;
        wait_drain();
        repeat (20) tick();
        chk_val("busy_accepts", 128'(acc_cnt - a0), 128'(1));
        chk_val("busy_outputs", 128'(out_cnt - o0), 128'(1));

        // Back-to-back with in_valid held high.
        exp_q.push_back(KAT_PT);
        exp_q.push_back(KAT_PT);
        in_data  = KAT_CT;
        in_valid = 1'b1;
        k = 0;
        n = 0;
        while (k < 2 && n < 100) begin
            @(negedge clk);
            if (in_ready) k++;
            n++;
        end
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        chk_val("b2b_accepts", 128'(k), 128'(2));
        chk_val("b2b_interval", 128'(acc_edge - prev_acc_edge), 128'(NR + 2));
        wait_drain();

        // Reset in the middle of the rounds.
        o0 = out_cnt;
        send_kat(1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk_val("midrst_out_valid", 128'(out_valid), 128'(0));
        chk_val("midrst_in_ready", 128'(in_ready), 128'(1));
        chk_val("midrst_rk_idx", 128'(rk_idx), 128'(NR));
        rst = 1'b0;
        exp_q.delete();
        repeat (20) tick();
        chk_val("midrst_no_out", 128'(out_cnt - o0), 128'(0));
        send_kat(1'b0);
        wait_drain();

`ifdef AES_INV_ROUND_ABORT_EN
        o0 = out_cnt;
        send_kat(1'b0);
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_val("abort_out_valid", 128'(out_valid), 128'(0));
        chk_val("abort_in_ready", 128'(in_ready), 128'(1));
        exp_q.delete();
        repeat (20) tick();
        chk_val("abort_no_out", 128'(out_cnt - o0), 128'(0));
        send_kat(1'b0);
        wait_drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_inv_round_engine.md
Name: aes_inv_round_engine

Overview:
- Iterative AES decryption datapath: takes one 128-bit ciphertext block and produces the plaintext after NUM_ROUNDS inverse rounds.
- Each round cycle applies InvShiftRows, InvSubBytes, AddRoundKey and then the existing inv_mixcolumns block, which it instantiates and feeds directly.
- Round keys come from the external key-schedule store through an index/data port.
- Sits between the AXI-facing wrapper and inv_mixcolumns.

Parameters:
- NUM_ROUNDS, 10, number of inverse rounds. Legal values are 10, 12 and 14; all use 128-bit round keys.
- KIDX_W, 4, width of the round-key index.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ciphertext valid
- in_ready  out  1  engine can accept a block
- in_data  in  128  ciphertext; byte s0 = [127:120], column-major (s0..s3 = column 0)
- rk_idx  out  KIDX_W  index of the round key requested this cycle
- rk_data  in  128  round key rk[rk_idx]; combinational from the key store, valid in the same cycle
- out_valid  out  1  plaintext valid
- out_ready  in  1  consumer accepts plaintext
- out_data  out  128  plaintext, same byte order as in_data

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, rk_idx=NUM_ROUNDS, state register=0, round counter=0, FSM=IDLE.
- FSM states are IDLE, ROUND and DONE.
- IDLE:
  - in_ready=1; rk_idx=NUM_ROUNDS.
  - On in_valid: state <= in_data ^ rk_data; rnd <= NUM_ROUNDS-1; go to ROUND.
- ROUND:
  - in_ready=0; rk_idx=rnd.
  - t = InvSubBytes(InvShiftRows(state)) ^ rk_data.
  - If rnd != 0: state <= inv_mixcolumns(t); rnd <= rnd-1.
  - If rnd == 0: state <= t; go to DONE.
- DONE:
  - out_valid=1; out_data=state; rk_idx=0 (don't-care for the key store).
  - out_data is held stable while out_ready=0.
  - On out_ready: go to IDLE; out_valid drops the next cycle.
- Latency: the accept edge is cycle 0. out_valid rises after NUM_ROUNDS+1 edges (11 for AES-128). Minimum initiation interval is NUM_ROUNDS+2 cycles.
- InvShiftRows rotates row r right by r columns (row 0 = s0,s4,s8,s12).
- in_valid while not in IDLE is ignored. in_data is not sampled and there is no error flag.
- No combinational path from out_ready to in_ready; in_ready depends only on the FSM.
- Reset asserted mid-operation aborts the block: outputs take reset values at the next edge and no partial result is emitted.
- rk_data is sampled only on ROUND cycles and on the accept cycle; it may change freely otherwise.

Optional Feature:
- Macro: AES_INV_ROUND_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 in ROUND or DONE forces IDLE at the next edge with out_valid=0; state is not cleared.
  - abort in IDLE has no effect, and abort overrides a same-cycle accept.
- When undefined: the port is absent and the behaviour is as above.

Decomposition:
- Shared package aes_pkg holds:
  - NUM_ROUNDS_128/192/256 constants;
  - the 256-entry inverse S-box constant table;
  - a state_t typedef (128-bit) and a byte_t typedef;
  - FSM state enum {IDLE, ROUND, DONE}.
- Sub-module aes_inv_sub_shift: purely combinational InvShiftRows plus 16 InvSubBytes lookups, 128-bit in/out.
- inv_mixcolumns is instantiated unchanged.

Test Plan:
- Known-answer test (FIPS-197 App. C.1): key schedule of 000102030405060708090a0b0c0d0e0f in the bench key store (rk[10]=13111d7fe3944a17f307a78b4d2b30c5, rk[0]=key). in_data=69c4e0d86a7b0430d8cdb78070b4c55a -> out_data=00112233445566778899aabbccddeeff; out_valid exactly 11 edges after accept; rk_idx sequence 10,9,...,1,0.
- Backpressure: same vector with out_ready=0 for 20 cycles -> out_valid and out_data stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
- Busy-ignore: second in_valid with in_data=ffff...ff during ROUND -> ignored; first result still 0011...eeff and no second out_valid.
- Back-to-back: two KAT blocks with in_valid held high and out_ready=1 -> two correct outputs, accepts 12 cycles apart.
- Reset mid-op: rst pulse at round 5 -> out_valid=0, in_ready=1 after the edge; a subsequent KAT still passes.
- Abort (macro on): abort at round 3 -> IDLE next cycle, no out_valid; next KAT correct.
